spi_result_tx: RTL and testbench

- Downstream of the 2x2 matmult core.
- Captures the four 16-bit results when calc_done pulses and streams them to the SPI master over MISO, one 16-bit word per chip-select frame, MSB first, SPI mode 0.
- SCLK and CS_N come from push-buttons; they are oversampled in the hz100 domain through synchronizers.
- Drives the `ready` flag the host polls before each word read.

---
 rtl/matmult_pkg.sv | 17 +
 rtl/sync_edge.sv | 30 +++
 rtl/spi_result_tx.sv | 139 +++++++++++++
 tb/tb_spi_result_tx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/matmult_pkg.sv
// Shared types and sizes for the 2x2 matmult datapath and its SPI result transmitter.
package matmult_pkg;

   localparam int WORD_W    = 16;
   localparam int NUM_WORDS = 4;

   typedef logic [WORD_W-1:0] result_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ARMED,
      SHIFT,
      NEXT
   } tx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for a slow asynchronous input, followed by a single-cycle
// rise/fall pulse generator. The reset level should match the input's idle level.
module sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise = sync_q[STAGES-1] & ~prev_q;
   assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_result_tx.sv
// Latches the four matmult results on calc_done and serves them to an SPI mode-0
// master, one MSB-first word per chip-select frame, from push-button SCLK/CS_N.
module spi_result_tx
   import matmult_pkg::*;
#(
   parameter int NUM_WORDS   = matmult_pkg::NUM_WORDS,
   parameter int WORD_W      = matmult_pkg::WORD_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         hz100,
   input  logic                         reset,
   input  logic                         calc_done,
   input  logic [NUM_WORDS*WORD_W-1:0]  results,
   input  logic                         sclk,
   input  logic                         cs_n,
   output logic                         miso,
   output logic                         ready,
   output logic [$clog2(NUM_WORDS)-1:0] word_idx,
   output logic                         all_sent
);

   localparam int IDX_W = $clog2(NUM_WORDS);
   localparam int CNT_W = $clog2(WORD_W + 1);

   tx_state_t state, state_next;

   logic [WORD_W-1:0] word_buf [NUM_WORDS];
   logic [WORD_W-1:0] shreg;
   logic [CNT_W-1:0]  bit_cnt;

   logic [1:0] sclk_ev, cs_ev;    // {rise, fall}
   logic       sclk_fall, cs_fall, cs_rise;
   logic       load_buf, load_shreg, shift_en, inc_idx, set_all;

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
      .clk   (hz100),
      .reset (reset),
      .d     (sclk),
      .rise  (sclk_ev[1]),
      .fall  (sclk_ev[0])
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk   (hz100),
      .reset (reset),
      .d     (cs_n),
      .rise  (cs_ev[1]),
      .fall  (cs_ev[0])
   );

   assign sclk_fall = (sclk_ev == 2'b01);
   assign cs_fall   = (cs_ev == 2'b01);
   assign cs_rise   = (cs_ev == 2'b10);

   always_ff @(posedge hz100 or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Handshake: ready=1 means a word sits in the shift register and the host may
   // open a frame; the host's CS_N fall consumes it and ready drops until the
   // next word (or the same word after an aborted frame) is loaded.
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      load_buf   = 1'b0;
      load_shreg = 1'b0;
      shift_en   = 1'b0;
      inc_idx    = 1'b0;
      set_all    = 1'b0;
      case (state)
         IDLE: begin
            if (calc_done) begin
               load_buf   = 1'b1;
               state_next = LOAD;
            end
         end
         LOAD: begin
            load_shreg = 1'b1;
            ready      = 1'b1;
            state_next = ARMED;
         end
         ARMED: begin
            ready = 1'b1;
            if (cs_fall) state_next = SHIFT;
         end
         SHIFT: begin
            // The last rising edge may be followed directly by CS_N rising, so
            // WORD_W-1 falls already mean every bit was sampled.
            if (cs_rise) begin
               if (bit_cnt >= CNT_W'(WORD_W - 1)) state_next = NEXT;
               else                               state_next = LOAD;
            end else if (sclk_fall) begin
               shift_en = 1'b1;
            end
         end
         NEXT: begin
            if (word_idx == IDX_W'(NUM_WORDS - 1)) begin
               set_all    = 1'b1;
               state_next = IDLE;
            end else begin
               inc_idx    = 1'b1;
               state_next = LOAD;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge hz100 or posedge reset) begin
      if (reset) begin
         word_buf <= '{default: '0};
         shreg    <= '0;
         bit_cnt  <= '0;
         word_idx <= '0;
         all_sent <= 1'b0;
      end else begin
         if (load_buf) begin
            for (int i = 0; i < NUM_WORDS; i++)
               word_buf[i] <= results[(NUM_WORDS-1-i)*WORD_W +: WORD_W];
            word_idx <= '0;
            all_sent <= 1'b0;
         end
         if (load_shreg) begin
            shreg   <= word_buf[word_idx];
            bit_cnt <= '0;
         end else if (shift_en) begin
            // Zero fill drains the register, so extra clocks shift out zeros.
            shreg <= {shreg[WORD_W-2:0], 1'b0};
            if (bit_cnt != CNT_W'(WORD_W)) bit_cnt <= bit_cnt + 1'b1;
         end
         if (inc_idx) word_idx <= word_idx + 1'b1;
         if (set_all) all_sent <= 1'b1;
      end
   end

   assign miso = (state == ARMED || state == SHIFT) ? shreg[WORD_W-1] : 1'b0;

endmodule

// File: tb/tb_spi_result_tx.sv
// Directed bench for spi_result_tx: acts as a slow SPI mode-0 master and checks
// returned words, ready/word_idx/all_sent behaviour, aborts and mid-frame reset.
module tb_spi_result_tx;

   logic        hz100 = 1'b0;
   logic        reset;
   logic        calc_done;
   logic [63:0] results;
   logic        sclk;
   logic        cs_n;
   logic        miso;
   logic        ready;
   logic [1:0]  word_idx;
   logic        all_sent;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [63:0] rx;

   spi_result_tx dut (
      .hz100     (hz100),
      .reset     (reset),
      .calc_done (calc_done),
      .results   (results),
      .sclk      (sclk),
      .cs_n      (cs_n),
      .miso      (miso),
      .ready     (ready),
      .word_idx  (word_idx),
      .all_sent  (all_sent)
   );

   // clock / reset block
   always #5 hz100 = ~hz100;

   task automatic cycles(input int n);
      repeat (n) @(negedge hz100);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic pulse_calc(input logic [63:0] r);
      results   = r;
      calc_done = 1'b1;
      cycles(1);
      calc_done = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 40 && ready !== 1'b1; i++) cycles(1);
      check(tag, ready, 1'b1);
   endtask

   // SCLK high phase; optionally fires a one-cycle calc_done inside it
   task automatic high_phase(input bit pulse);
      if (pulse) begin
         calc_done = 1'b1;
         cycles(1);
         calc_done = 1'b0;
         cycles(5);
      end else begin
         cycles(6);
      end
   endtask

   // One mode-0 frame of n_clk clocks; miso is captured just before each rising edge
   task automatic frame(input int n_clk, input int pulse_at);
      cs_n = 1'b0;
      cycles(12);
      check("ready_low_in_frame", ready, 1'b0);
      for (int i = 0; i < n_clk; i++) begin
         rx   = {rx[62:0], miso};
         sclk = 1'b1;
         high_phase(i == pulse_at);
         sclk = 1'b0;
         cycles(6);
      end
      cs_n = 1'b1;
      cycles(12);
   endtask

   initial begin
      reset     = 1'b1;
      calc_done = 1'b0;
      results   = '0;
      sclk      = 1'b0;
      cs_n      = 1'b1;
      rx        = '0;
      cycles(3);
      check("rst_miso", miso, 1'b0);
      check("rst_ready", ready, 1'b0);
      check("rst_all_sent", all_sent, 1'b0);
      check("rst_word_idx", word_idx, 2'd0);
      reset = 1'b0;
      cycles(3);
      check("idle_ready", ready, 1'b0);

      pulse_calc(64'h1234_ABCD_0001_8000);
      wait_ready("ready_w0");
      check("idx_w0", word_idx, 2'd0);

      // SCLK activity with CS_N high in ARMED must not shift
      repeat (3) begin
         sclk = 1'b1; cycles(6);
         sclk = 1'b0; cycles(6);
      end
      check("armed_ready", ready, 1'b1);
      check("armed_miso_msb", miso, 1'b0);

      frame(16, -1);
      check("word0", rx[15:0], 16'h1234);
      wait_ready("ready_w1");
      check("idx_w1", word_idx, 2'd1);
      check("all_sent_mid", all_sent, 1'b0);

      // aborted after 8 bits: same word re-offered
      frame(8, -1);
      check("abort_bits", rx[7:0], 8'hAB);
      wait_ready("ready_after_abort");
      check("idx_after_abort", word_idx, 2'd1);
      frame(16, -1);
      check("word1_retry", rx[15:0], 16'hABCD);
      wait_ready("ready_w2");
      check("idx_w2", word_idx, 2'd2);

      // calc_done with new data mid-word is ignored
      results = 64'hDEAD_BEEF_CAFE_F00D;
      frame(16, 5);
      check("word2", rx[15:0], 16'h0001);
      wait_ready("ready_w3");
      check("idx_w3", word_idx, 2'd3);
      frame(16, -1);
      check("word3", rx[15:0], 16'h8000);
      check("all_sent_done", all_sent, 1'b1);
      check("ready_after_last", ready, 1'b0);
      check("idx_after_last", word_idx, 2'd3);

      // new product; 20 clocks on an all-ones word
      pulse_calc(64'hFFFF_5A5A_0000_0000);
      check("all_sent_cleared", all_sent, 1'b0);
      wait_ready("ready_p2_w0");
      check("idx_p2_w0", word_idx, 2'd0);
      frame(20, -1);
      check("word_ffff_20clk", rx[19:0], 20'hFFFF0);
      wait_ready("ready_p2_w1");
      check("idx_p2_w1", word_idx, 2'd1);

      // reset in the middle of shifting word 0
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
      cycles(3);
      pulse_calc(64'hFFFF_0000_0000_0000);
      wait_ready("ready_p3_w0");
      cs_n = 1'b0;
      cycles(12);
      repeat (3) begin
         sclk = 1'b1; cycles(6);
         sclk = 1'b0; cycles(6);
      end
      check("miso_before_reset", miso, 1'b1);
      reset = 1'b1;
      #1;
      check("midreset_miso", miso, 1'b0);
      check("midreset_ready", ready, 1'b0);
      check("midreset_all_sent", all_sent, 1'b0);
      check("midreset_idx", word_idx, 2'd0);
      cs_n = 1'b1;
      sclk = 1'b0;
      cycles(3);
      reset = 1'b0;
      cycles(3);
      pulse_calc(64'h00FF_1111_2222_3333);
      wait_ready("ready_p4_w0");
      frame(16, -1);
      check("word_00ff", rx[15:0], 16'h00FF);
      wait_ready("ready_p4_w1");
      check("idx_p4_w1", word_idx, 2'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
